// File: rtl/mux_tree_pipelined.sv
// Pipelined N:1 binary-tree mux, one register per level, with auto-scan.
// Clk/Rst, I, Sel, Mode, In_Valid, En -> Out, Out_Valid, Out_Sel, Scan_Ch.
module mux_tree_pipelined #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS),
  localparam int LEVELS   = $clog2(CHANNELS)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Mode,
  input  logic                      In_Valid,
  input  logic                      En,
  output logic [WIDTH-1:0]          Out,
  output logic                      Out_Valid,
  output logic [SEL_W-1:0]          Out_Sel,
  output logic [SEL_W-1:0]          Scan_Ch
);

  if (CHANNELS < 2 ||
      (CHANNELS & (CHANNELS - 1)) != 0) begin : g_bad_channels
    $error("CHANNELS must be a power of 2 and >= 2");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("WIDTH must be >= 1");
  end

  // Tree nodes stored flat, level by level: level l starts at
  // CHANNELS - (CHANNELS >> l) and holds CHANNELS >> (l+1) nodes.
  localparam int NODES = CHANNELS - 1;

  logic [WIDTH-1:0] node [NODES];
  logic             vld  [LEVELS];
  logic [SEL_W-1:0] tag  [LEVELS];
  logic [SEL_W-1:0] scan_q;
  logic [SEL_W-1:0] eff_sel;

  assign eff_sel = Mode ? scan_q : Sel;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      scan_q <= '0;
    end else if (En && Mode && In_Valid) begin
      scan_q <= scan_q + SEL_W'(1);
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N = CHANNELS >> (l + 1);
    localparam int B = CHANNELS - (CHANNELS >> l);

    if (l == 0) begin : g_head
      always_ff @(posedge Clk) begin
        if (Rst) begin
          vld[0] <= 1'b0;
          tag[0] <= '0;
        end else if (En) begin
          vld[0] <= In_Valid;
          tag[0] <= eff_sel;
        end
      end

      for (genvar j = 0; j < N; j++) begin : g_node
        always_ff @(posedge Clk) begin
          if (Rst) begin
            node[j] <= '0;
          end else if (En) begin
            node[j] <= eff_sel[0]
              ? I[(2*j+1)*WIDTH +: WIDTH]
              : I[(2*j)*WIDTH +: WIDTH];
          end
        end
      end
    end else begin : g_body
      localparam int P = B - 2 * N;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          vld[l] <= 1'b0;
          tag[l] <= '0;
        end else if (En) begin
          vld[l] <= vld[l-1];
          tag[l] <= tag[l-1];
        end
      end

      // The captured tag carries the select bit this level needs.
      for (genvar j = 0; j < N; j++) begin : g_node
        always_ff @(posedge Clk) begin
          if (Rst) begin
            node[B+j] <= '0;
          end else if (En) begin
            node[B+j] <= tag[l-1][l]
              ? node[P+2*j+1]
              : node[P+2*j];
          end
        end
      end
    end
  end

  assign Out       = node[NODES-1];
  assign Out_Valid = vld[LEVELS-1];
  assign Out_Sel   = tag[LEVELS-1];
  assign Scan_Ch   = scan_q;

endmodule

// File: tb/tb_mux_tree_pipelined.sv
// Scoreboard bench for mux_tree_pipelined (4x8 main DUT, 8x16 scaling DUT).
// Driver pushes hand-computed expectations; a negedge monitor pops them.
module tb_mux_tree_pipelined;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode;
  logic        iv;
  logic        en;
  logic [1:0]  sel;
  logic [31:0] ich;
  logic [7:0]  out;
  logic        ov;
  logic [1:0]  osel;
  logic [1:0]  scan;

  mux_tree_pipelined #(.WIDTH(8), .CHANNELS(4)) dut (
    .Clk(clk), .Rst(rst), .I(ich), .Sel(sel),
    .Mode(mode), .In_Valid(iv), .En(en),
    .Out(out), .Out_Valid(ov), .Out_Sel(osel),
    .Scan_Ch(scan)
  );

  logic [127:0] ib;
  logic [2:0]   sel_b;
  logic         iv_b;
  logic [15:0]  out_b;
  logic         ov_b;
  logic [2:0]   osel_b;
  logic [2:0]   scan_b;

  mux_tree_pipelined #(.WIDTH(16), .CHANNELS(8)) dut8 (
    .Clk(clk), .Rst(rst), .I(ib), .Sel(sel_b),
    .Mode(1'b0), .In_Valid(iv_b), .En(1'b1),
    .Out(out_b), .Out_Valid(ov_b), .Out_Sel(osel_b),
    .Scan_Ch(scan_b)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  exp_t       q[$];
  exp_t       nxt;
  exp_t       last;
  exp_t       e;
  logic [1:0] scan_m;
  int         kind = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp(input exp_t x);
    chk("out_valid", {31'b0, ov}, {31'b0, x.v});
    if (x.v) begin
      chk("out_data", {24'b0, out}, {24'b0, x.d});
      chk("out_sel", {30'b0, osel}, {30'b0, x.s});
    end
  endtask

  // Model side: reacts to what the bench drove at each edge.
  // One bubble leads the queue because LEVELS-1 = 1 register
  // stands between the capturing edge and the output edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      q.push_back('0);
      scan_m = 2'd0;
      kind = 1;
    end else if (en) begin
      q.push_back(nxt);
      if (mode && iv) scan_m = scan_m + 2'd1;
      kind = 2;
    end else begin
      kind = 3;
    end
  end

  always @(negedge clk) begin
    case (kind)
      1: begin
        chk("rst_out", {24'b0, out}, 32'd0);
        chk("rst_valid", {31'b0, ov}, 32'd0);
        chk("rst_sel", {30'b0, osel}, 32'd0);
        chk("rst_scan", {30'b0, scan}, 32'd0);
      end
      2: begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL underflow: got empty queue expected entry");
        end else begin
          e = q.pop_front();
          last = e;
          cmp(e);
        end
        chk("scan", {30'b0, scan}, {30'b0, scan_m});
      end
      3: begin
        cmp(last);
        chk("stall_scan", {30'b0, scan}, {30'b0, scan_m});
      end
      default: ;
    endcase
  end

  task automatic drv(input logic v, input logic m,
                     input logic ee, input logic [1:0] s,
                     input logic [7:0] d, input logic [1:0] es);
    iv   = v;
    mode = m;
    en   = ee;
    sel  = s;
    nxt  = {v, d, es};
    @(posedge clk);
    #1;
  endtask

  int n;
  int nv;

  initial begin
    ich   = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 8; k++)
      ib[k*16 +: 16] = (k == 5) ? 16'hBEEF : 16'h0101 * k;
    rst   = 1'b1;
    en    = 1'b1;
    mode  = 1'b0;
    iv    = 1'b1;
    sel   = 2'd2;
    nxt   = '0;
    last  = '0;
    iv_b  = 1'b0;
    sel_b = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    drv(1, 0, 1, 0, 8'h11, 0);
    drv(1, 0, 1, 1, 8'h22, 1);
    drv(1, 0, 1, 2, 8'h33, 2);
    drv(1, 0, 1, 3, 8'h44, 3);

    drv(1, 1, 1, 3, 8'h11, 0);
    drv(1, 1, 1, 3, 8'h22, 1);
    drv(1, 1, 1, 0, 8'h33, 2);
    drv(1, 1, 1, 0, 8'h44, 3);
    drv(1, 1, 1, 2, 8'h11, 0);
    drv(1, 1, 1, 2, 8'h22, 1);
    chk("scan_after_wrap", {30'b0, scan}, 32'd2);

    drv(1, 0, 1, 1, 8'h22, 1);
    drv(1, 0, 1, 2, 8'h33, 2);
    repeat (3) drv(1, 1, 0, 3, 8'h44, 3);
    chk("scan_after_stall", {30'b0, scan}, 32'd2);
    drv(0, 0, 1, 0, 8'h00, 0);
    drv(1, 0, 1, 0, 8'h11, 0);
    drv(0, 0, 1, 0, 8'h00, 0);

    drv(1, 1, 1, 0, 8'h33, 2);
    drv(1, 1, 1, 0, 8'h44, 3);
    drv(1, 1, 1, 0, 8'h11, 0);
    rst = 1'b1;
    drv(1, 1, 1, 0, 8'h22, 1);
    rst = 1'b0;
    chk("scan_after_rst", {30'b0, scan}, 32'd0);
    drv(1, 1, 1, 2, 8'h11, 0);
    drv(1, 1, 1, 2, 8'h22, 1);
    drv(1, 0, 1, 3, 8'h44, 3);
    chk("scan_hold_mode0", {30'b0, scan}, 32'd2);
    repeat (3) drv(0, 0, 1, 0, 8'h00, 0);

    sel_b = 3'd5;
    iv_b  = 1'b1;
    @(posedge clk);
    #1;
    iv_b  = 1'b0;
    sel_b = 3'd0;
    n = 1;
    while (!ov_b && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b_latency", n, 32'd3);
    chk("b_data", {16'b0, out_b}, 32'h0000BEEF);
    chk("b_sel", {29'b0, osel_b}, 32'd5);
    @(posedge clk);
    #1;
    chk("b_single", {31'b0, ov_b}, 32'd0);
    chk("b_scan", {29'b0, scan_b}, 32'd0);

    nv = 0;
    foreach (q[i]) if (q[i].v) nv++;
    chk("drain", nv, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
